// File: rtl/rand_pos_picker.sv
// rand_pos_picker: draws a free (x,y) grid cell from an upstream LFSR with occupancy retry.
// Define RAND_POS_FALLBACK_EN to add a row-major SCAN of the grid once the try budget is exhausted.
module rand_pos_picker #(
   parameter int NUM_LEN = 10,
   parameter int GRID_W = 40,
   parameter int GRID_H = 30,
   parameter int MAX_TRIES = 16,
   localparam int XW = $clog2(GRID_W),
   localparam int YW = $clog2(GRID_H)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_LEN-1:0] rnd,
   output logic               lfsr_en,
   input  logic               req,
   input  logic               ack,
   output logic [XW-1:0]      cand_x,
   output logic [YW-1:0]      cand_y,
   input  logic               occupied,
   output logic [XW-1:0]      pos_x,
   output logic [YW-1:0]      pos_y,
   output logic               valid,
   output logic               busy,
   output logic               fail
);
   localparam int TW = $clog2(MAX_TRIES + 1);
   localparam logic [XW:0] GW = GRID_W[XW:0];
   localparam logic [YW:0] GH = GRID_H[YW:0];
   localparam logic [TW-1:0] MT = TW'(MAX_TRIES);
   typedef enum logic [2:0] {
      IDLE, DRAW_X, SAMP_X, DRAW_Y, SAMP_Y, CHECK, DONE
`ifdef RAND_POS_FALLBACK_EN
      , SCAN
`endif
   } state_t;
   state_t state, state_n;
   logic [TW-1:0] tries, tries_n, tries_inc;
   logic [XW-1:0] cx_n, px_n;
   logic [YW-1:0] cy_n, py_n;
   logic fail_n, x_ok, y_ok;
   logic unused_rnd;
   assign unused_rnd = ^rnd;
   assign x_ok = {1'b0, rnd[XW-1:0]} < GW;
   assign y_ok = {1'b0, rnd[YW-1:0]} < GH;
   assign tries_inc = tries + 1'b1;
   assign lfsr_en = state == DRAW_X || state == DRAW_Y;
   assign valid = state == DONE;
   assign busy = state != IDLE;
`ifdef RAND_POS_FALLBACK_EN
   logic x_last, y_last;
   assign x_last = cand_x == XW'(GRID_W - 1);
   assign y_last = cand_y == YW'(GRID_H - 1);
`endif
   always_comb begin
      state_n = state;
      tries_n = tries;
      cx_n = cand_x;
      cy_n = cand_y;
      px_n = pos_x;
      py_n = pos_y;
      fail_n = 1'b0;
      case (state)
         IDLE: if (req) begin
            tries_n = '0;
            state_n = DRAW_X;
         end
         DRAW_X: state_n = SAMP_X;
         SAMP_X: begin
            cx_n = x_ok ? rnd[XW-1:0] : cand_x;
            state_n = x_ok ? DRAW_Y : DRAW_X;
         end
         DRAW_Y: state_n = SAMP_Y;
         SAMP_Y: begin
            cy_n = y_ok ? rnd[YW-1:0] : cand_y;
            state_n = y_ok ? CHECK : DRAW_Y;
         end
         CHECK: if (!occupied) begin
            px_n = cand_x;
            py_n = cand_y;
            state_n = DONE;
         end else begin
            tries_n = tries_inc;
            if (tries_inc == MT) begin
`ifdef RAND_POS_FALLBACK_EN
               cx_n = '0;
               cy_n = '0;
               state_n = SCAN;
`else
               fail_n = 1'b1;
               state_n = IDLE;
`endif
            end else state_n = DRAW_X;
         end
         DONE: state_n = ack ? IDLE : DONE;
`ifdef RAND_POS_FALLBACK_EN
         SCAN: if (!occupied) begin
            px_n = cand_x;
            py_n = cand_y;
            state_n = DONE;
         end else if (x_last && y_last) begin
            fail_n = 1'b1;
            state_n = IDLE;
         end else begin
            cx_n = x_last ? '0 : cand_x + 1'b1;
            cy_n = x_last ? cand_y + 1'b1 : cand_y;
         end
`endif
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         tries <= '0;
         cand_x <= '0;
         cand_y <= '0;
         pos_x <= '0;
         pos_y <= '0;
         fail <= 1'b0;
      end else begin
         state <= state_n;
         tries <= tries_n;
         cand_x <= cx_n;
         cand_y <= cy_n;
         pos_x <= px_n;
         pos_y <= py_n;
         fail <= fail_n;
      end
   end
endmodule

// File: tb/tb_rand_pos_picker.sv
// tb_rand_pos_picker: directed checks of rand_pos_picker with a table-driven rnd source and occupancy map.
module tb_rand_pos_picker;
   logic clk = 1'b0, rst_n = 1'b1, req = 1'b0, ack = 1'b0;
   logic lfsr_en, valid, busy, fail, occupied;
   logic [9:0] rnd;
   logic [5:0] cand_x, pos_x, fx;
   logic [4:0] cand_y, pos_y, fy;
   logic [9:0] tbl [64];
   int nsteps = 0, base = 0, occ_mode = 0;
   int total = 0, bad = 0;
   int lat, nfail, fail_at;
   rand_pos_picker dut (
      .clk(clk), .rst_n(rst_n), .rnd(rnd), .lfsr_en(lfsr_en), .req(req), .ack(ack),
      .cand_x(cand_x), .cand_y(cand_y), .occupied(occupied), .pos_x(pos_x), .pos_y(pos_y),
      .valid(valid), .busy(busy), .fail(fail)
   );
   always #5 clk = ~clk;
   always @(posedge clk) if (lfsr_en) nsteps <= nsteps + 1;
   assign rnd = tbl[6'(nsteps - base)];
   assign occupied = occ_mode == 0 ? 1'b0 : occ_mode == 1 ? 1'b1 : !(cand_x == fx && cand_y == fy);
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask
   task automatic set_tbl(input logic [9:0] a, b, c, d, e);
      foreach (tbl[i]) tbl[i] = '0;
      tbl[1] = a; tbl[2] = b; tbl[3] = c; tbl[4] = d; tbl[5] = e;
      base = nsteps;
   endtask
   task automatic pick(input int limit);
      lat = 0; nfail = 0; fail_at = 0;
      req = 1'b1;
      do begin
         @(negedge clk);
         req = 1'b0;
         lat++;
         if (fail) begin
            nfail++;
            if (fail_at == 0) fail_at = lat;
         end
      end while (!valid && lat < limit);
   endtask
   task automatic do_ack();
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      check("ack_valid_drop", valid, 0);
   endtask
   function automatic logic [31:0] outs();
      return {6'd0, lfsr_en, valid, busy, fail, cand_x, cand_y, pos_x, pos_y};
   endfunction
   initial begin
      logic [10:0] held;
      foreach (tbl[i]) tbl[i] = '0;
      #1 rst_n = 1'b0;
      #1 check("reset_outs", outs(), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_no_req", {busy, lfsr_en}, 0);
      // upper bits of rnd must be ignored: 0x325 -> x=37, 0x3F3 -> y=19
      set_tbl(10'h325, 10'h3F3, 0, 0, 0);
      pick(50);
      check("basic_lat", lat, 6);
      check("basic_pos", {pos_x, pos_y}, {6'd37, 5'd19});
      check("basic_steps", nsteps - base, 2);
      check("done_flags", {valid, busy, lfsr_en}, 3'b110);
      held = {pos_x, pos_y};
      for (int i = 0; i < 10; i++) begin
         req = i[0];
         @(negedge clk);
      end
      req = 1'b0;
      check("hold_pos", {pos_x, pos_y}, held);
      check("hold_valid", valid, 1);
      check("hold_steps", nsteps - base, 2);
      req = 1'b1;
      do_ack();
      req = 1'b0;
      check("ack_req_idle", busy, 0);
      @(negedge clk);
      check("req_not_queued", busy, 0);
      set_tbl(45, 7, 29, 0, 0);
      pick(50);
      check("xrej_lat", lat, 8);
      check("xrej_pos", {pos_x, pos_y}, {6'd7, 5'd29});
      check("xrej_steps", nsteps - base, 3);
      do_ack();
      set_tbl(40, 39, 31, 0, 0);
      pick(50);
      check("bound_lat", lat, 10);
      check("bound_pos", {pos_x, pos_y}, {6'd39, 5'd0});
      check("bound_steps", nsteps - base, 4);
      do_ack();
      occ_mode = 2; fx = 6'd5; fy = 5'd5;
      set_tbl(1, 1, 5, 5, 0);
      pick(50);
      check("retry_lat", lat, 11);
      check("retry_pos", {pos_x, pos_y}, {6'd5, 5'd5});
      do_ack();
      occ_mode = 0;
      set_tbl(2, 3, 0, 0, 0);
      req = 1'b1;
      repeat (4) begin
         @(negedge clk);
         req = 1'b0;
      end
      check("in_samp_y", {cand_x, busy}, {6'd2, 1'b1});
      #2 rst_n = 1'b0;
      #1 check("rst_samp_y_outs", outs(), 0);
      @(negedge clk);
      rst_n = 1'b1;
      set_tbl(10, 20, 0, 0, 0);
      pick(50);
      check("post_rst_lat", lat, 6);
      check("post_rst_pos", {pos_x, pos_y}, {6'd10, 5'd20});
      do_ack();
`ifdef RAND_POS_FALLBACK_EN
      occ_mode = 2; fx = 6'd3; fy = 5'd1;
      set_tbl(0, 0, 0, 0, 0);
      pick(300);
      check("scan_lat", lat, 125);
      check("scan_pos", {pos_x, pos_y}, {6'd3, 5'd1});
      check("scan_flags", {valid, nfail[0]}, 2'b10);
      check("scan_steps", nsteps - base, 32);
      do_ack();
      set_tbl(0, 0, 0, 0, 0);
      pick(90);
      check("mid_scan_cand", cand_x, 9);
      #2 rst_n = 1'b0;
      #1 check("rst_scan_outs", outs(), 0);
`else
      occ_mode = 1;
      set_tbl(0, 0, 0, 0, 0);
      pick(120);
      check("exh_fail_cnt", nfail, 1);
      check("exh_fail_at", fail_at, 81);
      check("exh_no_valid", valid, 0);
      check("exh_busy", busy, 0);
      check("exh_steps", nsteps - base, 32);
      set_tbl(0, 0, 0, 0, 0);
      pick(40);
      check("mid_exh_busy", busy, 1);
      #2 rst_n = 1'b0;
      #1 check("rst_exh_outs", outs(), 0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      occ_mode = 0;
      set_tbl(33, 12, 0, 0, 0);
      pick(50);
      check("final_lat", lat, 6);
      check("final_pos", {pos_x, pos_y}, {6'd33, 5'd12});
      do_ack();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/rand_pos_picker.md
RAND_POS_PICKER -- requirements
Module: rand_pos_picker

Interface
REQ-001 Parameter NUM_LEN, default 10: width of the random word from the upstream LFSR.
REQ-002 Parameter GRID_W, default 40: number of grid columns; legal x is 0..GRID_W-1.
REQ-003 Parameter GRID_H, default 30: number of grid rows; legal y is 0..GRID_H-1.
REQ-004 Parameter MAX_TRIES, default 16: number of occupied candidates tolerated before give-up.
REQ-005 Derived widths: XW = clog2(GRID_W) (6 at default), YW = clog2(GRID_H) (5 at default); both SHALL be <= NUM_LEN.
REQ-006 clk  in  1: single clock; all state changes on the rising edge.
REQ-007 rst_n  in  1: reset, asynchronous, active-low.
REQ-008 rnd  in  NUM_LEN: current LFSR output word.
REQ-009 lfsr_en  out  1: advance request to the LFSR; the LFSR steps on each clk edge while this is high.
REQ-010 req  in  1: start a pick; sampled only in IDLE.
REQ-011 ack  in  1: consumer accepts pos_x/pos_y; sampled only in DONE.
REQ-012 cand_x  out  XW: candidate column presented for the occupancy lookup.
REQ-013 cand_y  out  YW: candidate row presented for the occupancy lookup.
REQ-014 occupied  in  1: combinational lookup result for (cand_x, cand_y), valid in the same cycle.
REQ-015 pos_x  out  XW: picked column, valid while valid=1.
REQ-016 pos_y  out  YW: picked row, valid while valid=1.
REQ-017 valid  out  1: result available; held until ack.
REQ-018 busy  out  1: high in every state except IDLE.
REQ-019 fail  out  1: one-cycle pulse when no free cell can be produced.

Function
REQ-020 The FSM SHALL have states IDLE, DRAW_X, SAMP_X, DRAW_Y, SAMP_Y, CHECK, DONE, plus SCAN when RAND_POS_FALLBACK_EN is defined.
REQ-021 IDLE with req=1: clear the try counter and go to DRAW_X; req=0: stay.
REQ-022 DRAW_X and DRAW_Y: drive lfsr_en=1 for exactly that one cycle, then go to SAMP_X or SAMP_Y respectively; lfsr_en SHALL be 0 in all other states.
REQ-023 SAMP_X: if rnd[XW-1:0] < GRID_W, latch it as cand_x and go to DRAW_Y; otherwise go to DRAW_X. A range rejection SHALL NOT count as a try.
REQ-024 SAMP_Y: if rnd[YW-1:0] < GRID_H, latch it as cand_y and go to CHECK; otherwise go to DRAW_Y.
REQ-025 CHECK with occupied=0: copy cand to pos_x/pos_y and go to DONE.
REQ-026 CHECK with occupied=1: increment the try counter; if the new count equals MAX_TRIES, apply the exhaust behaviour (REQ-034/035); otherwise go to DRAW_X.
REQ-027 DONE: valid=1. With ack=1, go to IDLE (valid drops in the next cycle). With ack=0, hold; pos_x/pos_y SHALL stay stable.
REQ-028 req arriving in any non-IDLE state SHALL be ignored and not queued.
REQ-029 ack arriving outside DONE SHALL be ignored.
REQ-030 req=1 together with ack=1 in DONE: the ack is taken and the req is ignored; a new pick starts only on a req seen in IDLE.
REQ-031 Best-case latency: req cycle to first valid cycle = 6 clocks (IDLE, DRAW_X, SAMP_X, DRAW_Y, SAMP_Y, CHECK).

Reset
REQ-032 rst_n=0 SHALL immediately force IDLE, try counter 0, cand/pos 0, valid=0, busy=0, fail=0 and lfsr_en=0, including mid-pick and mid-scan.
REQ-033 After rst_n rises, the block SHALL stay in IDLE until req=1.

Configuration
REQ-034 With macro RAND_POS_FALLBACK_EN defined, exhaust SHALL enter SCAN:
- start at (0,0) and present one cell per cycle on cand, row-major (x increments, wraps at GRID_W-1 to 0 with y+1);
- on the first occupied=0 cell, copy it to pos and go to DONE;
- after (GRID_W-1, GRID_H-1) is also occupied, pulse fail and go to IDLE.
REQ-035 With RAND_POS_FALLBACK_EN undefined, exhaust SHALL pulse fail for one cycle and go to IDLE; SCAN logic SHALL NOT exist.

Verification
REQ-036 Reference 10-bit LFSR upstream, occupied=0, req pulse -> valid at 6th cycle after req; pos_x<40, pos_y<30; lfsr_en high exactly 2 cycles.
REQ-037 Force rnd[5:0]=45 on first SAMP_X, then 7 -> extra DRAW_X/SAMP_X pair; pos_x=7; valid at 8 cycles.
REQ-038 occupied=1 for all cells, macro undefined -> fail pulses once after 16 CHECK cycles; valid never rises; busy=0 afterward.
REQ-039 Macro defined, only cell (3,1) free -> after 16 tries, SCAN yields pos=(3,1) after 44 scan cycles; valid=1, fail=0.
REQ-040 Hold ack=0 for 10 cycles in DONE with req toggling -> pos stable, no new draws; ack=1 -> valid=0 next cycle.
REQ-041 rst_n pulled low in SAMP_Y and during SCAN -> all outputs 0 asynchronously; next req starts a clean pick with 6-cycle latency.
